// File: rtl/sparse_mac_pkg.sv
// Shared defaults, FSM encoding and stream element type for the sparse dot-product engine.
package sparse_mac_pkg;

    localparam int DEF_NUM_CH = 2;
    localparam int DEF_IDX_W  = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 48;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_FLUSH,
        ST_OUT
    } isect_state_e;

    typedef struct packed {
        logic [DEF_IDX_W-1:0]         idx;
        logic signed [DEF_DATA_W-1:0] val;
        logic                         last;
    } elem_t;

    // Full-precision width of the product of every channel's value.
    function automatic int prod_width(input int num_ch, input int data_w);
        return num_ch * data_w;
    endfunction

endpackage

// File: rtl/sparse_isect.sv
// Head-of-stream intersection: compares channel indices, generates per-channel ready,
// tracks finished channels and sequences RUN -> DRAIN -> FLUSH -> OUT.
module sparse_isect
    import sparse_mac_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       valid_i,
    input  logic [NUM_CH*IDX_W-1:0] idx_i,
    input  logic [NUM_CH-1:0]       last_i,
    input  logic                    out_fire_i,
    output logic [NUM_CH-1:0]       ready_o,
    output logic                    match_o,
    output logic                    out_state_o
);

    isect_state_e      state_q;
    logic [NUM_CH-1:0] finished_q;
    logic [NUM_CH-1:0] finished_d;
    logic [NUM_CH-1:0] pop;
    logic [IDX_W-1:0]  maxIdx;
    logic              allValid;
    logic              headsEqual;

    always_comb begin
        maxIdx     = '0;
        allValid   = 1'b1;
        headsEqual = 1'b1;
        pop        = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!finished_q[c]) begin
                allValid = allValid & valid_i[c];
                if (idx_i[c*IDX_W +: IDX_W] > maxIdx) maxIdx = idx_i[c*IDX_W +: IDX_W];
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!finished_q[c] && (idx_i[c*IDX_W +: IDX_W] != maxIdx)) headsEqual = 1'b0;
        end
        case (state_q)
            ST_RUN: begin
                if (allValid) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        pop[c] = !finished_q[c] && (headsEqual || (idx_i[c*IDX_W +: IDX_W] < maxIdx));
                    end
                end
            end
            ST_DRAIN: pop = valid_i & ~finished_q;
            default:  pop = '0;
        endcase
        if (rst_i) pop = '0;
        finished_d = finished_q | (pop & last_i);
    end

    assign ready_o     = pop;
    assign match_o     = (state_q == ST_RUN) && allValid && headsEqual && !rst_i;
    assign out_state_o = (state_q == ST_OUT);

    // RUN and DRAIN share the exit rule: all finished -> FLUSH, some finished -> DRAIN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            finished_q <= '0;
        end else begin
            case (state_q)
                ST_RUN, ST_DRAIN: begin
                    finished_q <= finished_d;
                    if (&finished_d)      state_q <= ST_FLUSH;
                    else if (|finished_d) state_q <= ST_DRAIN;
                end
                ST_FLUSH: state_q <= ST_OUT;
                ST_OUT: begin
                    if (out_fire_i) begin
                        state_q    <= ST_RUN;
                        finished_q <= '0;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: rtl/sparse_dot_engine.sv
// Sparse dot-product engine: intersects NUM_CH compressed (index, value, last) streams,
// multiplies matched values and returns one accumulated result per vector.
module sparse_dot_engine
    import sparse_mac_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     mac_clk,
    input  logic                     mac_rst,
    input  logic [NUM_CH-1:0]        in_valid_i,
    output logic [NUM_CH-1:0]        in_ready_o,
    input  logic [NUM_CH*IDX_W-1:0]  in_idx_i,
    input  logic [NUM_CH*DATA_W-1:0] in_val_i,
    input  logic [NUM_CH-1:0]        in_last_i,
    input  logic                     sat_en_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ACC_W-1:0]         out_data_o,
    output logic [CNT_W-1:0]         out_match_o,
    output logic                     out_ovf_o
);

    localparam int PROD_W = prod_width(NUM_CH, DATA_W);
    localparam int EXT_W  = ACC_W + 1 - PROD_W;

    logic              match;
    logic              outState;
    logic              outFire;
    logic [DATA_W-1:0] lane;
    logic [PROD_W-1:0] factor;
    logic [PROD_W-1:0] prodComb;
    logic [PROD_W-1:0] prod_q;
    logic              prod_vld_q;
    logic [ACC_W:0]    accSum;
    logic              accOvf;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic              out_valid_q;
    logic [ACC_W-1:0]  out_data_q;
    logic [CNT_W-1:0]  out_match_q;
    logic              out_ovf_q;

    sparse_isect #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_isect (
        .clk_i       (mac_clk),
        .rst_i       (mac_rst),
        .valid_i     (in_valid_i),
        .idx_i       (in_idx_i),
        .last_i      (in_last_i),
        .out_fire_i  (outFire),
        .ready_o     (in_ready_o),
        .match_o     (match),
        .out_state_o (outState)
    );

    assign outFire = out_valid_q & out_ready_i;

    // Low PROD_W bits of an unsigned multiply equal the signed product once both are sign-extended.
    always_comb begin
        lane     = in_val_i[DATA_W-1:0];
        prodComb = {{(PROD_W-DATA_W){lane[DATA_W-1]}}, lane};
        factor   = '0;
        for (int c = 1; c < NUM_CH; c++) begin
            lane     = in_val_i[c*DATA_W +: DATA_W];
            factor   = {{(PROD_W-DATA_W){lane[DATA_W-1]}}, lane};
            prodComb = prodComb * factor;
        end
    end

    always_comb begin
        accSum = {acc_q[ACC_W-1], acc_q} + {{EXT_W{prod_q[PROD_W-1]}}, prod_q};
        accOvf = accSum[ACC_W] ^ accSum[ACC_W-1];
        if (accOvf && sat_en_i) begin
            acc_d = accSum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_d = accSum[ACC_W-1:0];
        end
    end

    always_ff @(posedge mac_clk) begin
        if (mac_rst) begin
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_match_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            prod_vld_q <= match;
            if (match) prod_q <= prodComb;
            if (outFire) begin
                acc_q       <= '0;
                cnt_q       <= '0;
                ovf_q       <= 1'b0;
                out_valid_q <= 1'b0;
            end else if (prod_vld_q) begin
                acc_q <= acc_d;
                cnt_q <= (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                ovf_q <= ovf_q | accOvf;
            end
            if (outState && !out_valid_q) begin
                out_valid_q <= 1'b1;
                out_data_q  <= acc_q;
                out_match_q <= cnt_q;
                out_ovf_q   <= ovf_q;
            end
        end
    end

    assign out_valid_o = out_valid_q & ~mac_rst;
    assign out_data_o  = mac_rst ? '0 : out_data_q;
    assign out_match_o = mac_rst ? '0 : out_match_q;
    assign out_ovf_o   = out_ovf_q & ~mac_rst;

endmodule
